// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler.
// Sequences NS/EW greens, yellows and all-red clearances, inserts a pedestrian
// walk phase on request, and gives emergency preemption (road 1 wins ties).
// Every phase length is cycle-counted from a duration latched on phase entry.
module traffic_phase_scheduler #(
    parameter int TW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] Tgreen_min,
    input  logic [TW-1:0] Tgreen_max,
    input  logic [TW-1:0] Tyellow,
    input  logic [TW-1:0] Tallred,
    input  logic [TW-1:0] Twalk,
    input  logic          car_ns,
    input  logic          car_ew,
    input  logic          ped_req,
    input  logic          emerg_ns,
    input  logic          emerg_ew,
    output logic          R1,
    output logic          Y1,
    output logic          G1,
    output logic          R2,
    output logic          Y2,
    output logic          G2,
    output logic          walk,
    output logic          ped_pending,
    output logic [2:0]    phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR    = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        WALK  = 3'd5,
        AR_NS = 3'd6
    } state_t;

    localparam logic          DIR_NS = 1'b0;
    localparam logic          DIR_EW = 1'b1;
    localparam logic [TW-1:0] ONE_T  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    // Lamp vector order: {R1, Y1, G1, R2, Y2, G2, walk}
    localparam logic [6:0]    LAMPS_ALL_RED = 7'b100_100_0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] dur_q, dur_d;
    logic          dur_loaded_q, dur_loaded_d;
    logic          next_dir_q, next_dir_d;
    logic          from_walk_q, from_walk_d;
    logic          ped_q, ped_d;
    logic [6:0]    lamps_q, lamps_d;

    logic [TW-1:0] eff_dur;
    logic [CW-1:0] last_cnt;
    logic          timer_done;
    logic          min_done;
    logic          opp_ns;
    logic          opp_ew;

    // A green rests by simply holding, which the green states already do when
    // nothing opposes them, so the maximum-green value never alters the sequence.
    logic unused_gmax;
    assign unused_gmax = ^Tgreen_max;

    // Zero durations behave as one cycle.
    function automatic logic [TW-1:0] norm_dur(input logic [TW-1:0] t);
        return (t == '0) ? ONE_T : t;
    endfunction

    // Duration to latch when entering state s.
    function automatic logic [TW-1:0] entry_dur(input state_t s,
                                                input logic [TW-1:0] t_gmin,
                                                input logic [TW-1:0] t_y,
                                                input logic [TW-1:0] t_ar,
                                                input logic [TW-1:0] t_walk);
        logic [TW-1:0] t;
        case (s)
            NS_G, EW_G: t = t_gmin;
            NS_Y, EW_Y: t = t_y;
            WALK:       t = t_walk;
            default:    t = t_ar;
        endcase
        return norm_dur(t);
    endfunction

    // The reset state has no latched duration yet; it uses Tallred on its first cycle.
    assign eff_dur    = dur_loaded_q ? dur_q : norm_dur(Tallred);
    assign last_cnt   = {{(CW-TW){1'b0}}, eff_dur} - ONE_C;
    assign timer_done = (cnt_q == last_cnt);
    assign min_done   = (cnt_q >= last_cnt);
    assign opp_ns     = car_ew | emerg_ew | ped_q;
    assign opp_ew     = car_ns | emerg_ns | ped_q;

    // Next-state, counter, duration latch, pedestrian latch and lamp decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + ONE_C;
        dur_d        = eff_dur;
        dur_loaded_d = 1'b1;
        next_dir_d   = next_dir_q;
        from_walk_d  = from_walk_q;
        ped_d        = ped_q | ped_req;
        lamps_d      = LAMPS_ALL_RED;

        case (state_q)
            AR_NS: begin
                if (timer_done) state_d = NS_G;
            end
            NS_G: begin
                if (emerg_ns)                state_d = NS_G;
                else if (emerg_ew)           state_d = NS_Y;
                else if (min_done && opp_ns) state_d = NS_Y;
            end
            EW_G: begin
                // Road 1 emergency outranks road 2 emergency.
                if (emerg_ns)                state_d = EW_Y;
                else if (emerg_ew)           state_d = EW_G;
                else if (min_done && opp_ew) state_d = EW_Y;
            end
            NS_Y: begin
                if (timer_done) begin
                    state_d     = AR;
                    next_dir_d  = DIR_EW;
                    from_walk_d = 1'b0;
                end
            end
            EW_Y: begin
                if (timer_done) begin
                    state_d     = AR;
                    next_dir_d  = DIR_NS;
                    from_walk_d = 1'b0;
                end
            end
            AR: begin
                if (timer_done) begin
                    if (emerg_ns)                     state_d = NS_G;
                    else if (emerg_ew)                state_d = EW_G;
                    // After a walk the next phase is always a green, so a
                    // request made during the walk waits one green.
                    else if (ped_q && !from_walk_q)   state_d = WALK;
                    else if (next_dir_q == DIR_NS)    state_d = NS_G;
                    else                              state_d = EW_G;
                end
            end
            WALK: begin
                if (timer_done) begin
                    state_d     = AR;
                    from_walk_d = 1'b1;
                end
            end
            default: state_d = AR_NS;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            dur_d = entry_dur(state_d, Tgreen_min, Tyellow, Tallred, Twalk);
            if (state_d == WALK) ped_d = 1'b0;
        end

        case (state_d)
            NS_G:    lamps_d = 7'b001_100_0;
            NS_Y:    lamps_d = 7'b010_100_0;
            EW_G:    lamps_d = 7'b100_001_0;
            EW_Y:    lamps_d = 7'b100_010_0;
            WALK:    lamps_d = 7'b100_100_1;
            default: lamps_d = LAMPS_ALL_RED;
        endcase
    end

    // State and datapath registers with asynchronous return to reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= AR_NS;
            cnt_q        <= '0;
            dur_q        <= '0;
            dur_loaded_q <= 1'b0;
            next_dir_q   <= DIR_NS;
            from_walk_q  <= 1'b0;
            ped_q        <= 1'b0;
            lamps_q      <= LAMPS_ALL_RED;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dur_q        <= dur_d;
            dur_loaded_q <= dur_loaded_d;
            next_dir_q   <= next_dir_d;
            from_walk_q  <= from_walk_d;
            ped_q        <= ped_d;
            lamps_q      <= lamps_d;
        end
    end

    assign {R1, Y1, G1, R2, Y2, G2, walk} = lamps_q;
    assign ped_pending = ped_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed testbench for traffic_phase_scheduler.
module tb_traffic_phase_scheduler;

    localparam int TW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] Tgreen_min, Tgreen_max, Tyellow, Tallred, Twalk;
    logic          car_ns, car_ew, ped_req, emerg_ns, emerg_ew;
    logic          R1, Y1, G1, R2, Y2, G2, walk, ped_pending;
    logic [2:0]    phase;

    int checks   = 0;
    int failures = 0;

    traffic_phase_scheduler #(.TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .Tgreen_min(Tgreen_min), .Tgreen_max(Tgreen_max), .Tyellow(Tyellow),
        .Tallred(Tallred), .Twalk(Twalk),
        .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
        .emerg_ns(emerg_ns), .emerg_ew(emerg_ew),
        .R1(R1), .Y1(Y1), .G1(G1), .R2(R2), .Y2(Y2), .G2(G2),
        .walk(walk), .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    // Expected lamps {R1,Y1,G1,R2,Y2,G2,walk} for each state encoding.
    function automatic logic [6:0] lamps_for(input logic [2:0] p);
        case (p)
            3'd0:    return 7'b001_100_0;
            3'd1:    return 7'b010_100_0;
            3'd3:    return 7'b100_001_0;
            3'd4:    return 7'b100_010_0;
            3'd5:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_phase);
        logic [6:0] obs_l;
        logic [6:0] exp_l;
        obs_l = {R1, Y1, G1, R2, Y2, G2, walk};
        exp_l = lamps_for(exp_phase);
        checks++;
        assert (phase === exp_phase) else begin
            failures++;
            $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, exp_phase);
        end
        checks++;
        assert (obs_l === exp_l) else begin
            failures++;
            $error("FAIL %s lamps observed=%b expected=%b", tag, obs_l, exp_l);
        end
    endtask

    task automatic chk_ped(input string tag, input logic exp_v);
        checks++;
        assert (ped_pending === exp_v) else begin
            failures++;
            $error("FAIL %s ped_pending observed=%b expected=%b", tag, ped_pending, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        Tallred = 6'd2; Tgreen_min = 6'd4; Tgreen_max = 6'd10; Tyellow = 6'd3; Twalk = 6'd5;
        car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0; emerg_ns = 1'b0; emerg_ew = 1'b0;

        // Reset state and power-up clearance
        step(2); chk("reset", 3'd6); chk_ped("reset_ped", 1'b0);
        rst = 1'b0;
        step(1); chk("arns_c1", 3'd6);
        step(1); chk("nsg_entry", 3'd0);

        // Resting green; 256 cycles would wrap an 8-bit counter back to 0
        step(256); chk("nsg_rest", 3'd0);
        car_ew = 1'b1; step(1); chk("nsy_after_car", 3'd1); car_ew = 1'b0;
        step(2); chk("nsy_hold", 3'd1);
        step(1); chk("ar1", 3'd2);
        step(1); chk("ar1_c2", 3'd2);
        step(1); chk("ewg", 3'd3);

        // Pedestrian request during EW green
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk_ped("ped_latched", 1'b1); chk("ewg_ped", 3'd3);
        step(2); chk("ewg_min", 3'd3);
        step(1); chk("ewy", 3'd4);
        step(3); chk("ar_after_ewy", 3'd2);
        step(2); chk("walk", 3'd5); chk_ped("ped_clr", 1'b0);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk_ped("ped_in_walk", 1'b1); chk("walk_c1", 3'd5);
        step(3); chk("walk_c4", 3'd5);
        step(1); chk("ar_after_walk", 3'd2);
        step(2); chk("nsg_after_walk", 3'd0); chk_ped("ped_still", 1'b1);
        step(3); chk("nsg_min_ped", 3'd0);
        step(1); chk("nsy_ped", 3'd1);
        step(3); chk("ar_ped2", 3'd2);
        step(2); chk("walk2", 3'd5); chk_ped("ped_clr2", 1'b0);
        step(5); chk("ar_w2", 3'd2);
        step(2); chk("ewg2", 3'd3);

        // Road 1 emergency during EW green
        emerg_ns = 1'b1; step(1); chk("ewy_emerg", 3'd4);
        step(3); chk("ar_emerg", 3'd2);
        step(2); chk("nsg_emerg", 3'd0);
        car_ew = 1'b1; step(10); chk("nsg_emerg_hold", 3'd0);
        emerg_ns = 1'b0; step(1); chk("nsy_release", 3'd1); car_ew = 1'b0;
        step(5); chk("ewg3", 3'd3);

        // Both emergencies: road 1 wins
        emerg_ns = 1'b1; emerg_ew = 1'b1;
        step(1); chk("ewy_both", 3'd4);
        step(3); chk("ar_both", 3'd2);
        step(2); chk("nsg_both", 3'd0);
        step(2); chk("nsg_both_hold", 3'd0);
        emerg_ns = 1'b0; step(1); chk("nsy_emerg_ew", 3'd1); emerg_ew = 1'b0;
        step(5); chk("ewg4", 3'd3);

        // Minimum green: request at cnt=1 holds green until cnt=3
        step(1); car_ns = 1'b1;
        step(2); chk("ewg_min_hold", 3'd3);
        step(1); chk("ewy_min", 3'd4); car_ns = 1'b0;

        // Yellow length stays latched when the input changes mid-phase
        Tyellow = 6'd10;
        step(2); chk("ewy_latched", 3'd4);
        step(1); chk("ar_latched", 3'd2);

        // Zero durations act as one cycle
        Tyellow = 6'd0; Twalk = 6'd0;
        step(2); chk("nsg5", 3'd0);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        step(2); chk("nsg5_min", 3'd0);
        step(1); chk("nsy_zero", 3'd1);
        step(1); chk("ar_zero", 3'd2);
        step(2); chk("walk_zero", 3'd5);
        step(1); chk("ar_walk_zero", 3'd2);
        step(2); chk("ewg5", 3'd3);

        // Clear wins over a request on the WALK entry edge, then async reset mid-WALK
        Twalk = 6'd5;
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        step(2); chk("ewg5_min", 3'd3);
        step(1); chk("ewy5", 3'd4);
        step(1); chk("ar5", 3'd2);
        step(1); chk("ar5_c2", 3'd2);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("walk5", 3'd5); chk_ped("ped_clear_wins", 1'b0);
        step(1); chk("walk5_c1", 3'd5);
        #2 rst = 1'b1;
        #1 chk("async_rst", 3'd6); chk_ped("rst_ped", 1'b0);
        step(1); rst = 1'b0;
        step(1); chk("arns2", 3'd6);
        step(1); chk("nsg_after_rst", 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Two-road intersection phase scheduler. It sequences road 1 (NS) and road 2 (EW) lights through green, yellow and all-red phases, and inserts a pedestrian walk phase on request. It arbitrates green time between vehicle-sensor requests and gives emergency preemption. All timing is cycle-counted from runtime timing inputs, so the block drops in wherever the fixed-cycle light sequencer is used today.

Parameters:
TW, 6, width of each timing input
CW, 8, width of the internal phase counter (CW > TW)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
Tgreen_min  in  TW  minimum green duration, cycles
Tgreen_max  in  TW  green duration after which green rests if unrequested
Tyellow  in  TW  yellow duration, cycles
Tallred  in  TW  all-red clearance duration, cycles
Twalk  in  TW  pedestrian walk duration, cycles
car_ns  in  1  vehicle waiting on road 1, level
car_ew  in  1  vehicle waiting on road 2, level
ped_req  in  1  pedestrian button, pulse or level
emerg_ns  in  1  emergency preempt for road 1, level
emerg_ew  in  1  emergency preempt for road 2, level
R1,Y1,G1  out  1  road 1 lamps
R2,Y2,G2  out  1  road 2 lamps
walk  out  1  pedestrian walk lamp
ped_pending  out  1  latched pedestrian request
phase  out  3  current state encoding

Behaviour:
- Single clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: state AR_NS, cnt=0, R1=R2=1, all other lamps 0, walk=0, ped_pending=0, next_dir=NS.
- States and encodings:
  - NS_G=0: G1,R2
  - NS_Y=1: Y1,R2
  - AR=2: R1,R2
  - EW_G=3: R1,G2
  - EW_Y=4: R1,Y2
  - WALK=5: R1,R2,walk
  - AR_NS=6: R1,R2, used only after reset
- Lamp outputs:
  - Each road's {R,Y,G} is exactly one-hot in every cycle.
  - G1 and G2 are never both 1. Neither G is ever 1 while walk=1.
- Duration rule:
  - The active timing value is latched into a register on state entry. Mid-phase input changes do not affect the current phase.
  - A value of 0 is treated as 1.
  - A phase of duration T occupies exactly T cycles: cnt runs 0..T-1, and the state exits on the edge where cnt==T-1.
  - cnt resets to 0 on every transition.
  - cnt saturates at all-ones and never wraps.
- AR_NS: after Tallred cycles -> NS_G.
- NS_G: opp = car_ew | emerg_ew | ped_pending.
  - emerg_ns=1 -> hold NS_G. This overrides everything.
  - Else emerg_ew=1 -> NS_Y on the next edge. The minimum green is skipped.
  - Else cnt >= Tgreen_min-1 and opp -> NS_Y.
  - Else cnt >= Tgreen_max-1 and !opp -> rest in NS_G.
  - EW_G is symmetric with the roles swapped.
- If both emergencies are asserted, road 1 wins: NS_G holds, and EW_G goes to EW_Y immediately.
- NS_Y / EW_Y: last for Tyellow cycles, then -> AR. On that transition next_dir is set to the opposite road.
- AR: after Tallred cycles:
  - ped_pending=1 and no emergency asserted -> WALK.
  - Otherwise -> next_dir green.
  - Emergency override: if any emergency is asserted, go to that road's green; road 1 wins ties.
- WALK: last for Twalk cycles, then -> AR.
- ped_pending:
  - Set on any cycle where ped_req=1.
  - Cleared on the transition into WALK.
  - If ped_req=1 on that same edge, the clear wins.
  - ped_req during WALK sets ped_pending again, giving another walk after the next green.
- Reset asserted mid-phase: asynchronous return to the reset values.
- After rst deasserts, the first rising edge starts counting AR_NS from cnt=0.

Test Plan:
- Reset with Tallred=2, Tgreen_min=4, Tgreen_max=10, no requests -> AR_NS for 2 cycles, then G1=1,R2=1. NS_G rests indefinitely; cnt saturates at 255 without wrap.
- From resting NS_G, pulse car_ew=1 -> NS_Y on the next edge. Tyellow=3 gives 3 cycles Y1, then 2 cycles all-red, then EW_G with G2=1.
- In NS_G at cnt=1 with Tgreen_min=4, assert car_ew -> green holds until cnt=3, then NS_Y. Total G1 time is exactly 4 cycles.
- Pulse ped_req for 1 cycle during EW_G -> ped_pending=1. After EW_Y and AR: WALK for Twalk=5 cycles with walk=1, R1=R2=1. ped_pending clears on WALK entry. Then AR, then NS_G.
- During EW_G at cnt=0, assert emerg_ns -> EW_Y immediately, then AR, then NS_G. NS_G holds while emerg_ns=1 even with car_ew=1. Assert both emergencies during EW_G -> same road-1 outcome.
- Set Tyellow=0 and Twalk=0 -> each phase lasts 1 cycle. Change Tyellow mid-yellow -> the current yellow keeps the latched length. Assert rst mid-WALK -> walk=0, R1=R2=1 asynchronously.
